// File: rtl/seg_frame_reader.sv
// Reads back the two digits shown on a common-anode 7-segment display
// by sampling its segment/anode nets and waiting for a stable frame.
module seg_frame_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  input  logic [1:0] an,
  input  logic       sel,
  output logic [3:0] units,
  output logic [3:0] tens,
  output logic [6:0] value,
  output logic       valid,
  output logic       bad_pat
);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    HOLD
  } state_t;

  localparam logic [9:0] IDLE_FRAME = {7'h7F, 2'b11, 1'b0};
  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  logic [9:0] sync1_q, frame_q, prev_q;
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] units_q, units_d;
  logic [3:0] tens_q, tens_d;
  logic [6:0] value_q, value_d;
  logic       valid_q, valid_d;
  logic       bad_q, bad_d;

  logic [6:0] f_seg;
  logic [1:0] f_an;
  logic       f_sel;
  logic       chg, an_idle, cap, ok;
  logic       to_units, to_tens;
  logic [3:0] dig;

  assign f_seg   = frame_q[9:3];
  assign f_an    = frame_q[2:1];
  assign f_sel   = frame_q[0];
  assign chg     = frame_q != prev_q;
  assign an_idle = f_an == 2'b11;

  // previous frame feeds the change detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= IDLE_FRAME;
      frame_q <= IDLE_FRAME;
      prev_q  <= IDLE_FRAME;
    end else begin
      sync1_q <= {seg, an, sel};
      frame_q <= sync1_q;
      prev_q  <= frame_q;
    end
  end

  always_comb begin
    ok  = 1'b1;
    dig = 4'd0;
    case (f_seg)
      7'b0000001: dig = 4'd0;
      7'b1001111: dig = 4'd1;
      7'b0010010: dig = 4'd2;
      7'b0000110: dig = 4'd3;
      7'b1001100: dig = 4'd4;
      7'b0100100: dig = 4'd5;
      7'b0100000: dig = 4'd6;
      7'b0001111: dig = 4'd7;
      7'b0000000: dig = 4'd8;
      7'b0000100: dig = 4'd9;
      default:    ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (!an_idle) begin
          state_d = TRACK;
          cnt_d   = 8'd1;
        end
      end
      TRACK: begin
        if (an_idle) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (chg) begin
          cnt_d = 8'd1;
        end else if (cnt_q >= STABLE) begin
          cap     = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        if (chg) begin
          state_d = an_idle ? IDLE : TRACK;
          cnt_d   = an_idle ? 8'd0 : 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  assign to_units = (f_an == 2'b10) || ((f_an == 2'b00) && f_sel);
  assign to_tens  = (f_an == 2'b01) || ((f_an == 2'b00) && !f_sel);

  always_comb begin
    units_d = units_q;
    tens_d  = tens_q;
    bad_d   = cap && !ok;
    if (cap && ok && to_units) units_d = dig;
    if (cap && ok && to_tens)  tens_d  = dig;
    value_d = ({3'b000, tens_q} * 7'd10) + {3'b000, units_q};
    valid_d = value_d != value_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      units_q <= 4'd0;
      tens_q  <= 4'd0;
      value_q <= 7'd0;
      valid_q <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      units_q <= units_d;
      tens_q  <= tens_d;
      value_q <= value_d;
      valid_q <= valid_d;
      bad_q   <= bad_d;
    end
  end

  assign units   = units_q;
  assign tens    = tens_q;
  assign value   = value_q;
  assign valid   = valid_q;
  assign bad_pat = bad_q;

endmodule

// File: tb/tb_seg_frame_reader.sv
// Directed bench for seg_frame_reader: exact-edge sequences plus a
// table of held frames with expected digits, value and pulse counts.
module tb_seg_frame_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg = 7'h7F;
  logic [1:0] an = 2'b11;
  logic       sel = 1'b0;
  logic [3:0] units, tens;
  logic [6:0] value;
  logic       valid, bad_pat;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [6:0] seg;
    logic [1:0] an;
    logic       sel;
    int         hold;
    int         eu;
    int         et;
    int         ev;
    int         nv;
    int         nb;
  } vec_t;

  vec_t vecs[16];

  seg_frame_reader #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .an(an), .sel(sel),
    .units(units), .tens(tens), .value(value),
    .valid(valid), .bad_pat(bad_pat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [6:0] s, input logic [1:0] a,
                              input logic sl, input int h, input int u,
                              input int t, input int v, input int nv,
                              input int nb);
    vec_t r;
    r.seg = s; r.an = a; r.sel = sl; r.hold = h;
    r.eu = u; r.et = t; r.ev = v; r.nv = nv; r.nb = nb;
    return r;
  endfunction

  initial begin
    int cv, cb;
    vecs[0]  = mk(7'b0000110, 2'b01, 0, 110, 5, 3, 35, 1, 0);
    vecs[1]  = mk(7'b1111111, 2'b11, 0, 10, 5, 3, 35, 0, 0);
    vecs[2]  = mk(7'b1111111, 2'b10, 0, 12, 5, 3, 35, 0, 1);
    vecs[3]  = mk(7'b0000000, 2'b00, 0, 12, 5, 8, 85, 1, 0);
    vecs[4]  = mk(7'b0000000, 2'b00, 1, 12, 8, 8, 88, 1, 0);
    vecs[5]  = mk(7'b0000000, 2'b10, 0, 12, 8, 8, 88, 0, 0);
    vecs[6]  = mk(7'b0000001, 2'b01, 0, 12, 8, 0, 8, 1, 0);
    vecs[7]  = mk(7'b1001111, 2'b10, 0, 12, 1, 0, 1, 1, 0);
    vecs[8]  = mk(7'b0010010, 2'b10, 0, 12, 2, 0, 2, 1, 0);
    vecs[9]  = mk(7'b0100000, 2'b01, 0, 12, 2, 6, 62, 1, 0);
    vecs[10] = mk(7'b1001111, 2'b10, 0, 3, 2, 6, 62, 0, 0);
    vecs[11] = mk(7'b0000100, 2'b10, 0, 12, 9, 6, 69, 1, 0);
    vecs[12] = mk(7'b0001111, 2'b10, 0, 12, 7, 6, 67, 1, 0);
    vecs[13] = mk(7'b0001001, 2'b10, 0, 12, 7, 6, 67, 0, 1);
    vecs[14] = mk(7'b1001100, 2'b01, 0, 12, 7, 4, 47, 1, 0);
    vecs[15] = mk(7'b0000110, 2'b10, 0, 4, 7, 4, 47, 0, 0);

    repeat (3) step();
    check("rst_units", units, 0);
    check("rst_tens", tens, 0);
    check("rst_value", value, 0);
    check("rst_valid", valid, 0);
    check("rst_bad", bad_pat, 0);
    rst_n = 1'b1;
    step();

    // exact edge timing for the first capture
    seg = 7'b0100100; an = 2'b10; sel = 1'b0;
    cv = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (valid) cv++;
      if (k == 5) check("t5_units", units, 0);
      if (k == 6) check("t6_units", units, 5);
      if (k == 6) check("t6_value", value, 0);
      if (k == 7) check("t7_value", value, 5);
      if (k == 7) check("t7_valid", valid, 1);
      if (k == 8) check("t8_valid", valid, 0);
    end
    check("t_nvalid", cv, 1);

    for (int i = 0; i < 16; i++) begin
      seg = vecs[i].seg; an = vecs[i].an; sel = vecs[i].sel;
      cv = 0; cb = 0;
      for (int k = 0; k < vecs[i].hold; k++) begin
        step();
        if (valid) cv++;
        if (bad_pat) cb++;
      end
      check($sformatf("v%0d_units", i), units, vecs[i].eu);
      check($sformatf("v%0d_tens", i), tens, vecs[i].et);
      check($sformatf("v%0d_value", i), value, vecs[i].ev);
      check($sformatf("v%0d_nvalid", i), cv, vecs[i].nv);
      check($sformatf("v%0d_nbad", i), cb, vecs[i].nb);
    end

    // reset in the middle of a pending capture of 7
    seg = 7'b0001111; an = 2'b01; sel = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("mr_units", units, 0);
    check("mr_tens", tens, 0);
    check("mr_value", value, 0);
    step();
    rst_n = 1'b1;
    cv = 0; cb = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (valid) cv++;
      if (bad_pat) cb++;
      if (k == 5) check("mr5_tens", tens, 0);
      if (k == 6) check("mr6_tens", tens, 7);
      if (k == 7) check("mr7_value", value, 70);
    end
    check("mr_nvalid", cv, 1);
    check("mr_nbad", cb, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
